// File: rtl/fifo_stream_reader.sv
// Pulls words from a first-word-fall-through-less FIFO (one-cycle read latency) into a
// 2-entry skid buffer and presents them as a valid/ready stream framed into fixed-length packets.
module fifo_stream_reader #(
  parameter int DW      = 32,
  parameter int PKT_LEN = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          fifo_empty,
  output logic          fifo_rd_en,
  input  logic [DW-1:0] fifo_rd_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic [15:0]   pkt_cnt
);

  localparam int            BW        = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

  logic [1:0]    r_occ;
  logic          r_infl;
  logic          r_valid;
  logic          r_last;
  logic [DW-1:0] r_head;
  logic [DW-1:0] r_tail;
  logic [BW-1:0] r_beat;
  logic [15:0]   r_pkt_cnt;

  logic          w_pop;
  logic [2:0]    w_level;
  logic [1:0]    w_occ_nxt;
  logic [DW-1:0] w_head_nxt;
  logic [DW-1:0] w_tail_nxt;
  logic [BW-1:0] w_beat_nxt;

  function automatic logic [BW-1:0] beat_next(input logic [BW-1:0] b);
    if (b == LAST_BEAT) return '0;
    return b + 1'b1;
  endfunction

  // Only request a word if its slot is guaranteed once it lands, counting the word
  // already in flight and the slot freed by this cycle's transfer.
  assign w_pop      = r_valid & m_ready;
  assign w_level    = {1'b0, r_occ} + {2'b00, r_infl} - {2'b00, w_pop};
  assign fifo_rd_en = ~RST & ~fifo_empty & (w_level < 3'd2);

  always_comb begin
    w_occ_nxt  = r_occ;
    w_head_nxt = r_head;
    w_tail_nxt = r_tail;
    case ({w_pop, r_infl})
      2'b01: begin
        if (r_occ == 2'd0) w_head_nxt = fifo_rd_data;
        else               w_tail_nxt = fifo_rd_data;
        w_occ_nxt = r_occ + 2'd1;
      end
      2'b10: begin
        w_head_nxt = r_tail;
        w_occ_nxt  = r_occ - 2'd1;
      end
      2'b11: begin
        if (r_occ == 2'd1) begin
          w_head_nxt = fifo_rd_data;
        end else begin
          w_head_nxt = r_tail;
          w_tail_nxt = fifo_rd_data;
        end
      end
      default: ;
    endcase
    w_beat_nxt = w_pop ? beat_next(r_beat) : r_beat;
  end

  // Reset also clears the in-flight flag, so data returned during reset is never captured.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_occ     <= 2'd0;
      r_infl    <= 1'b0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_head    <= '0;
      r_tail    <= '0;
      r_beat    <= '0;
      r_pkt_cnt <= 16'd0;
    end else begin
      r_infl  <= fifo_rd_en;
      r_occ   <= w_occ_nxt;
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_beat  <= w_beat_nxt;
      r_valid <= (w_occ_nxt != 2'd0);
      r_last  <= (w_occ_nxt != 2'd0) && (w_beat_nxt == LAST_BEAT);
      if (w_pop && r_last) r_pkt_cnt <= r_pkt_cnt + 16'd1;
    end
  end

  assign m_valid = r_valid;
  assign m_data  = r_head;
  assign m_last  = r_last;
  assign pkt_cnt = r_pkt_cnt;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: a small FIFO model with one-cycle read latency feeds the PKT_LEN=4
// instance; a second PKT_LEN=1 instance streams 65536 packets for the counter wrap.
module tb_fifo_stream_reader;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [31:0] fifo_rd_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic [15:0] pkt_cnt;

  logic        w_empty   = 1'b1;
  logic        w_rd_en;
  logic [31:0] w_rd_data = 32'h5A5A_0001;
  logic        w_valid;
  logic        w_ready   = 1'b0;
  logic [31:0] w_data;
  logic        w_last;
  logic [15:0] w_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [0:255];
  int          wr_ptr     = 0;
  int          rd_ptr     = 0;
  logic        hold_empty = 1'b0;
  logic        underflow  = 1'b0;

  assign fifo_empty = (wr_ptr == rd_ptr) || hold_empty;

  always @(posedge CLK) begin
    if (fifo_rd_en) begin
      if ((wr_ptr != rd_ptr) && !hold_empty) begin
        fifo_rd_data <= mem[rd_ptr[7:0]];
        rd_ptr       <= rd_ptr + 1;
      end else begin
        fifo_rd_data <= 32'hDEAD_BEEF;
        underflow    <= 1'b1;
      end
    end
  end

  fifo_stream_reader #(.DW(32), .PKT_LEN(4)) dut (
    .CLK(CLK), .RST(RST), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .pkt_cnt(pkt_cnt)
  );

  fifo_stream_reader #(.DW(32), .PKT_LEN(1)) u_wrap (
    .CLK(CLK), .RST(RST), .fifo_empty(w_empty), .fifo_rd_en(w_rd_en),
    .fifo_rd_data(w_rd_data), .m_valid(w_valid), .m_ready(w_ready),
    .m_data(w_data), .m_last(w_last), .pkt_cnt(w_cnt)
  );

  task automatic push(input logic [31:0] d);
    mem[wr_ptr[7:0]] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    m_ready = 1'b0;
    repeat (2) @(negedge CLK);
    n_tests++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b, expected 0", fifo_rd_en); end
    n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", m_valid); end
    n_tests++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b, expected 0", m_last); end
    n_tests++; if (m_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h, expected 0", m_data); end
    n_tests++; if (pkt_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_pkt_cnt: got %h, expected 0", pkt_cnt); end
    n_tests++; if (w_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_wrap_cnt: got %h, expected 0", w_cnt); end
    RST = 1'b0;
  endtask

  task automatic test_basic;
    int k = 0, cyc = 0, first = -1, lastc = -1;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(32'h10 + i);
    while (k < 8 && cyc < 40) begin
      #1;
      if (m_valid && m_ready) begin
        if (first < 0) first = cyc;
        lastc = cyc;
        n_tests++;
        if (m_data !== 32'(32'h10 + k) || m_last !== 1'(k % 4 == 3)) begin
          n_fail++;
          $display("FAIL basic_beat%0d: got data=%h last=%b, expected data=%h last=%b",
                   k, m_data, m_last, 32'(32'h10 + k), 1'(k % 4 == 3));
        end
        k++;
      end
      @(negedge CLK); cyc++;
    end
    n_tests++; if (k != 8) begin n_fail++; $display("FAIL basic_count: got %0d beats, expected 8", k); end
    n_tests++; if (first != 2) begin n_fail++; $display("FAIL basic_latency: first valid at cycle %0d, expected 2", first); end
    n_tests++; if (lastc - first != 7) begin n_fail++; $display("FAIL basic_rate: span %0d cycles, expected 7", lastc - first); end
    n_tests++; if (pkt_cnt !== 16'd2) begin n_fail++; $display("FAIL basic_pkt_cnt: got %0d, expected 2", pkt_cnt); end
    n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: m_valid=%b, expected 0", m_valid); end
  endtask

  task automatic test_backpressure;
    int pops = 0, k = 0, cyc = 0;
    bit hold_ok = 1'b1;
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(32'h20 + i);
    for (int i = 0; i < 10; i++) begin
      #1;
      if (fifo_rd_en) pops++;
      if (i >= 2 && (m_valid !== 1'b1 || m_data !== 32'h20)) hold_ok = 1'b0;
      @(negedge CLK);
    end
    n_tests++; if (pops != 2) begin n_fail++; $display("FAIL bp_pops: got %0d, expected 2", pops); end
    n_tests++; if (!hold_ok) begin n_fail++; $display("FAIL bp_hold: valid/data not held, now valid=%b data=%h, expected 1/00000020", m_valid, m_data); end
    n_tests++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL bp_rd_en_full: got %b, expected 0", fifo_rd_en); end
    m_ready = 1'b1;
    while (k < 8 && cyc < 40) begin
      #1;
      if (m_valid && m_ready) begin
        n_tests++;
        if (m_data !== 32'(32'h20 + k) || m_last !== 1'(k % 4 == 3)) begin
          n_fail++;
          $display("FAIL bp_beat%0d: got data=%h last=%b, expected data=%h last=%b",
                   k, m_data, m_last, 32'(32'h20 + k), 1'(k % 4 == 3));
        end
        k++;
      end
      @(negedge CLK); cyc++;
    end
    n_tests++; if (k != 8) begin n_fail++; $display("FAIL bp_count: got %0d beats, expected 8", k); end
    n_tests++; if (pkt_cnt !== 16'd4) begin n_fail++; $display("FAIL bp_pkt_cnt: got %0d, expected 4", pkt_cnt); end
  endtask

  task automatic test_empty_toggle;
    int k = 0, cyc = 0;
    bit bad_rd = 1'b0;
    for (int i = 0; i < 12; i++) push(32'h30 + i);
    while (k < 12 && cyc < 300) begin
      hold_empty = ~hold_empty;
      m_ready    = 1'($urandom_range(0, 1));
      #1;
      if (fifo_rd_en && fifo_empty) bad_rd = 1'b1;
      if (m_valid && m_ready) begin
        n_tests++;
        if (m_data !== 32'(32'h30 + k) || m_last !== 1'(k % 4 == 3)) begin
          n_fail++;
          $display("FAIL empty_beat%0d: got data=%h last=%b, expected data=%h last=%b",
                   k, m_data, m_last, 32'(32'h30 + k), 1'(k % 4 == 3));
        end
        k++;
      end
      @(negedge CLK); cyc++;
    end
    hold_empty = 1'b0;
    m_ready    = 1'b1;
    n_tests++; if (k != 12) begin n_fail++; $display("FAIL empty_count: got %0d beats, expected 12", k); end
    n_tests++; if (bad_rd) begin n_fail++; $display("FAIL empty_rd_en: rd_en seen high while empty, expected never"); end
    n_tests++; if (pkt_cnt !== 16'd7) begin n_fail++; $display("FAIL empty_pkt_cnt: got %0d, expected 7", pkt_cnt); end
  endtask

  task automatic test_reset_mid;
    int k = 0, cyc = 0;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(32'h40 + i);
    while (k < 3 && cyc < 40) begin
      #1;
      if (m_valid && m_ready) begin
        n_tests++;
        if (m_data !== 32'(32'h40 + k)) begin
          n_fail++; $display("FAIL rst_pre_beat%0d: got %h, expected %h", k, m_data, 32'(32'h40 + k));
        end
        k++;
      end
      @(negedge CLK); cyc++;
    end
    RST = 1'b1;
    #1;
    n_tests++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rd_en: got %b, expected 0", fifo_rd_en); end
    @(negedge CLK);
    n_tests++; if (m_valid !== 1'b0 || m_last !== 1'b0) begin n_fail++; $display("FAIL rst_mid_flags: got valid=%b last=%b, expected 0/0", m_valid, m_last); end
    n_tests++; if (m_data !== 32'h0) begin n_fail++; $display("FAIL rst_mid_data: got %h, expected 0", m_data); end
    n_tests++; if (pkt_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_mid_pkt_cnt: got %0d, expected 0", pkt_cnt); end
    RST = 1'b0;
    push(32'h48);
    k = 0; cyc = 0;
    while (k < 4 && cyc < 40) begin
      #1;
      if (m_valid && m_ready) begin
        n_tests++;
        if (m_data !== 32'(32'h45 + k) || m_last !== 1'(k == 3)) begin
          n_fail++;
          $display("FAIL rst_post_beat%0d: got data=%h last=%b, expected data=%h last=%b",
                   k, m_data, m_last, 32'(32'h45 + k), 1'(k == 3));
        end
        k++;
      end
      @(negedge CLK); cyc++;
    end
    n_tests++; if (k != 4) begin n_fail++; $display("FAIL rst_post_count: got %0d beats, expected 4", k); end
    n_tests++; if (pkt_cnt !== 16'd1) begin n_fail++; $display("FAIL rst_post_pkt_cnt: got %0d, expected 1", pkt_cnt); end
  endtask

  task automatic test_wrap;
    int n = 0, cyc = 0;
    w_empty = 1'b0;
    w_ready = 1'b1;
    while (n < 65536 && cyc < 70000) begin
      @(negedge CLK); cyc++;
      if (w_valid) begin
        n++;
        if (n == 1) begin
          n_tests++; if (w_last !== 1'b1) begin n_fail++; $display("FAIL wrap_last: got %b, expected 1", w_last); end
        end
        if (n == 65535) begin
          @(posedge CLK); #1;
          n_tests++; if (w_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_ffff: got %h, expected ffff", w_cnt); end
        end
        if (n == 65536) begin
          @(posedge CLK); #1;
          w_ready = 1'b0;
          w_empty = 1'b1;
          n_tests++; if (w_cnt !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero: got %h, expected 0000", w_cnt); end
        end
      end
    end
    n_tests++; if (n != 65536) begin n_fail++; $display("FAIL wrap_count: got %0d transfers, expected 65536", n); end
    @(negedge CLK);
    n_tests++; if (w_rd_en !== 1'b0) begin n_fail++; $display("FAIL wrap_rd_en_idle: got %b, expected 0", w_rd_en); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_toggle();
    test_reset_mid();
    test_wrap();
    n_tests++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL fifo_underflow: got %b, expected 0", underflow); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
